// File: rtl/popcount_shift_seq.sv
// ---------------------------------------------------------------------------
// popcount_shift_seq
//
// Purpose:
//   Latches a W-bit signed operand and counts its set bits CHUNK bits per
//   cycle, reusing a single narrow adder. It then arithmetic-right-shifts the
//   latched operand by that count, which produces a sign-filled normalised
//   result. A start/done handshake connects it to the operand source and to
//   the result consumer.
//
// Ports:
//   clk     in   1    rising-edge clock
//   rst     in   1    asynchronous active-high reset
//   start   in   1    request, sampled only while idle
//   A       in   W    signed operand, captured on the accepting edge
//   ack     in   1    result consumed (only used when DONE_HOLD_EN is defined)
//   busy    out  1    high from the accepting edge until the op retires
//   done    out  1    count/result valid
//   count   out  CW   number of ones in the latched operand
//   result  out  W    latched operand >>> count, sign-filled
//
// Configuration macro:
//   DONE_HOLD_EN  undefined : done is a one-cycle pulse, and ack is ignored.
//                 defined   : done holds until ack is seen at an edge.
// ---------------------------------------------------------------------------
module popcount_shift_seq #(
   parameter int W     = 127,
   parameter int CW    = 7,
   parameter int CHUNK = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  A,
   input  logic          ack,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count,
   output logic [W-1:0]  result
);

   localparam int NCH = (W + CHUNK - 1) / CHUNK;
   localparam int PW  = NCH * CHUNK;
   localparam int IXW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      SHIFT,
      DONE
   } stateType;

   stateType        state;
   stateType        nextState;
   logic [W-1:0]    opReg;
   logic [IXW-1:0]  idx;
   logic [PW-1:0]   padded;
   logic [CHUNK-1:0] chunk;
   logic [CW-1:0]   chunkOnes;

   // The operand is zero-extended up to a whole number of chunks. This makes
   // the bits above W in the last chunk count as zero.
   always_comb begin
      padded = '0;
      padded[W-1:0] = opReg;
      chunk = padded[idx*CHUNK +: CHUNK];
   end

   // This is the single narrow ones-counter that all COUNT cycles share.
   always_comb begin
      chunkOnes = '0;
      for (int b = 0; b < CHUNK; b++) begin
         chunkOnes = chunkOnes + CW'(chunk[b]);
      end
   end

   // State register and datapath. count accumulates one chunk per COUNT
   // cycle. result is written only on the SHIFT edge, so it stays stable
   // from then until the next op reaches SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         opReg  <= '0;
         idx    <= '0;
         count  <= '0;
         result <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (start) begin
                  opReg <= A;
                  count <= '0;
                  idx   <= '0;
               end
            end
            COUNT: begin
               count <= count + chunkOnes;
               idx   <= idx + IXW'(1);
            end
            SHIFT: begin
               result <= $signed(opReg) >>> count;
            end
            default: begin
            end
         endcase
      end
   end

`ifndef DONE_HOLD_EN
   // ack is not used in pulse mode. The *unused* name marks it as
   // deliberately dropped.
   logic unusedAck;
   assign unusedAck = ack;
`endif

   // Next-state logic. COUNT leaves after it has summed the last chunk.
   // ack is looked at only while in DONE, so an ack that arrives during
   // SHIFT is ignored.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (start) nextState = COUNT;
         COUNT: if (idx == IXW'(NCH - 1)) nextState = SHIFT;
         SHIFT: nextState = DONE;
         DONE: begin
`ifdef DONE_HOLD_EN
            if (ack) nextState = IDLE;
`else
            nextState = IDLE;
`endif
         end
         default: nextState = IDLE;
      endcase
   end

   // Status outputs are decoded straight from the state. This lets reset
   // clear them at once.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

endmodule
